// File: rtl/v_pkg.sv
// Shared vector front-end definitions: major opcodes and the queue entry layout.
// Both the instruction queue and v_decoder use these.
package v_pkg;

  localparam logic [6:0] OPC_LTYPE = 7'b0000111;
  localparam logic [6:0] OPC_STYPE = 7'b0100111;
  localparam logic [6:0] OPC_RTYPE = 7'b1010111;

  localparam int V_XLEN = 32;

  typedef struct packed {
    logic [31:0]       instr;
    logic [V_XLEN-1:0] rs1_data;
    logic [V_XLEN-1:0] rs2_data;
  } v_iq_entry_t;

  function automatic logic opc_is_mem(input logic [6:0] opc);
    return (opc == OPC_LTYPE) || (opc == OPC_STYPE);
  endfunction

  function automatic logic opc_is_supported(input logic [6:0] opc);
    return opc_is_mem(opc) || (opc == OPC_RTYPE);
  endfunction

endpackage

// File: rtl/v_sync_fifo.sv
// Generic single-clock FIFO with a combinational head read.
// Flush overrides push and pop.
module v_sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == PW'(0) + (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (do_push && (wr_ptr_q == PW'(gi))) mem_d[gi] = wdata;
    end

    always_ff @(posedge clk) begin
      mem_q[gi] <= mem_d[gi];
    end
  end

endmodule

// File: rtl/v_instr_queue.sv
// In-order vector instruction queue ahead of v_decoder: filters opcodes,
// holds memory ops at the head while the LSU is busy, zeroes outputs when empty.
module v_instr_queue
  import v_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_rs1_data,
  input  logic [XLEN-1:0]         in_rs2_data,
  input  logic                    flush,
  input  logic                    lsu_busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    illegal_instr
);

  localparam int EW = 32 + 2 * XLEN;

  logic [EW-1:0] head;
  logic          full, empty;
  logic          accept, supported, push, pop, head_is_mem;
  logic          illegal_q, illegal_d;
  logic [31:0]   head_instr;

  assign in_ready  = !full && !flush;
  assign accept    = in_valid && in_ready;
  assign supported = opc_is_supported(in_instr[6:0]);
  assign push      = accept && supported;

  assign head_instr  = head[EW-1 -: 32];
  assign head_is_mem = !empty && opc_is_mem(head_instr[6:0]);
  assign out_valid   = !empty && !(head_is_mem && lsu_busy);
  assign pop         = out_valid && out_ready;

  v_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({in_instr, in_rs1_data, in_rs2_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Uninitialised storage must never leak to the decoder, so gate on empty.
  always_comb begin
    out_instr    = '0;
    out_rs1_data = '0;
    out_rs2_data = '0;
    if (!empty) begin
      out_instr    = head_instr;
      out_rs1_data = head[2*XLEN-1 -: XLEN];
      out_rs2_data = head[XLEN-1:0];
    end
  end

  always_comb begin
    illegal_d = accept && !supported;
  end

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_v_instr_queue.sv
// Directed bench for v_instr_queue: queue-based reference model checked every cycle,
// plus literal expectations per scenario.
module tb_v_instr_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam logic [6:0] L_OPC = 7'b0000111;
  localparam logic [6:0] S_OPC = 7'b0100111;
  localparam logic [6:0] R_OPC = 7'b1010111;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_rs1_data = '0;
  logic [XLEN-1:0] in_rs2_data = '0;
  logic            flush = 1'b0;
  logic            lsu_busy = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [2:0]      count;
  logic            illegal_instr;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [95:0] m_q[$];
  logic        m_ill = 1'b0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  v_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .flush(flush), .lsu_busy(lsu_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .count(count), .illegal_instr(illegal_instr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_mem(input logic [31:0] w);
    return (w[6:0] == L_OPC) || (w[6:0] == S_OPC);
  endfunction

  function automatic logic is_ok(input logic [31:0] w);
    return is_mem(w) || (w[6:0] == R_OPC);
  endfunction

  function automatic logic m_valid();
    if (m_q.size() == 0) return 1'b0;
    return !(is_mem(m_q[0][95:64]) && lsu_busy);
  endfunction

  // Reference model: advance a plain queue by the queue's rules at every edge.
  always @(posedge clk) begin
    logic rdy, vld, acc;
    rdy = (m_q.size() != DEPTH) && !flush;
    vld = m_valid();
    acc = in_valid && rdy;
    if (rst || flush) begin
      m_q.delete();
      m_ill = 1'b0;
    end else begin
      m_ill = acc && !is_ok(in_instr);
      if (vld && out_ready) void'(m_q.pop_front());
      if (acc && is_ok(in_instr)) m_q.push_back({in_instr, in_rs1_data, in_rs2_data});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [95:0] h;
      h = (m_q.size() != 0) ? m_q[0] : '0;
      chk("count", 64'(count), 64'(m_q.size()));
      chk("in_ready", 64'(in_ready), 64'((m_q.size() != DEPTH) && !flush));
      chk("out_valid", 64'(out_valid), 64'(m_valid()));
      chk("out_instr", 64'(out_instr), 64'(h[95:64]));
      chk("out_rs1", 64'(out_rs1_data), 64'(h[63:32]));
      chk("out_rs2", 64'(out_rs2_data), 64'(h[31:0]));
      chk("illegal", 64'(illegal_instr), 64'(m_ill));
      if (out_valid && out_ready) got.push_back(out_instr);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic offer(input logic [31:0] w);
    in_valid    = 1'b1;
    in_instr    = w;
    in_rs1_data = w ^ 32'h1111_0000;
    in_rs2_data = ~w;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_instr = '0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1'b1;
    lsu_busy  = 1'b0;
    for (int i = 0; i < 20 && count != 0; i++) step();
    chk("drain_done", 64'(count), 64'd0);
    out_ready = 1'b0;
  endtask

  logic [31:0] seq[10];
  int lsu_low;
  int ill_cycles;

  initial begin
    step(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_instr", 64'(out_instr), 64'd0);

    // 1: three RTYPE words, no consumer
    offer(32'h0220_8057); step();
    offer(32'h0231_0057); step();
    offer(32'h0242_0057); step();
    idle();
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    chk("t1_head", 64'(out_instr), 64'h0220_8057);
    chk("t1_rs1", 64'(out_rs1_data), 64'h1331_8057);
    drain();

    // 2: fill, then offer a 5th word on the full cycle while popping
    got.delete();
    for (int i = 1; i <= 4; i++) begin
      offer(32'h0200_0057 | (32'(i) << 12));
      step();
    end
    offer(32'h0200_5057);
    chk("t2_full_count", 64'(count), 64'd4);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    idle();
    chk("t2_no_5th", 64'(count), 64'd3);
    drain();
    chk("t2_npop", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk("t2_order", 64'(got[i]), 64'(32'h0200_0057 | (32'(i + 1) << 12)));

    // 3: LTYPE at head blocked by lsu_busy, RTYPE behind
    got.delete();
    lsu_busy  = 1'b1;
    out_ready = 1'b1;
    offer(32'h0205_0007); step();
    offer(32'h0220_8057); step();
    idle();
    lsu_low = 0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid) lsu_low++;
      step();
    end
    chk("t3_blocked_cycles", 64'(lsu_low), 64'd5);
    chk("t3_count_held", 64'(count), 64'd2);
    lsu_busy = 1'b0;
    drain();
    chk("t3_first", 64'(got.size() > 0 ? got[0] : 32'h0), 64'h0205_0007);
    chk("t3_second", 64'(got.size() > 1 ? got[1] : 32'h0), 64'h0220_8057);

    // 4: unsupported opcode
    offer(32'h0220_8057); step();
    offer(32'h0000_0033); step();
    idle();
    ill_cycles = 0;
    chk("t4_count", 64'(count), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (illegal_instr) ill_cycles++;
      step();
    end
    chk("t4_pulse_len", 64'(ill_cycles), 64'd1);
    drain();

    // 5: flush overrides push and pop
    offer(32'h0220_8057); step();
    offer(32'h0231_0057); step();
    chk("t5_count2", 64'(count), 64'd2);
    offer(32'h0000_0033);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_no_illegal", 64'(illegal_instr), 64'd0);
    step();
    chk("t5_word_lost", 64'(count), 64'd0);
    out_ready = 1'b0;

    // 6: streaming 1/cycle across pointer wrap
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      seq[i] = 32'h0300_0057 | (32'(i) << 8);
      offer(seq[i]);
      step();
      chk("t6_count", 64'(count), 64'd1);
    end
    drain();
    chk("t6_npop", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk("t6_seq", 64'(got[i]), 64'(seq[i]));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
